// File: rtl/ieee754_pkg.sv
// Shared constants and FSM state type for the IEEE-754 single-precision
// normalise/round/pack datapath.
package ieee754_pkg;

  localparam int unsigned EXP_BIAS = 127;
  localparam int          EXP_MAX  = 255;
  localparam int unsigned MANT_W   = 23;
  localparam int unsigned FRAC_W   = 32;

  localparam logic [30:0] INF_MAG  = 31'h7F800000;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } state_e;

endpackage

// File: rtl/ieee754_round_pack.sv
// Combinational round-to-nearest-even and pack of a normalised significand
// into an IEEE-754 single, with infinity saturation and flush-to-zero.
module ieee754_round_pack
  import ieee754_pkg::*;
(
  input  logic               sign_i,
  input  logic [MANT_W:0]    mant_i,
  input  logic signed [31:0] exp_i,
  input  logic               g_i,
  input  logic               r_i,
  input  logic               s_i,
  input  logic               zero_i,
  output logic [31:0]        float_o
);

  logic               inc;
  logic [MANT_W+1:0]  m_rnd;
  logic [MANT_W-1:0]  frac;
  logic signed [31:0] exp_adj;

  always_comb begin
    inc     = g_i & (r_i | s_i | mant_i[0]);
    m_rnd   = {1'b0, mant_i} + (MANT_W + 2)'(inc);
    // A rounding carry renormalises by one; the remaining fraction is zero.
    frac    = m_rnd[MANT_W+1] ? m_rnd[MANT_W:1] : m_rnd[MANT_W-1:0];
    exp_adj = exp_i + 32'(m_rnd[MANT_W+1]);

    if (zero_i)
      float_o = {sign_i, 31'b0};
    else if (exp_adj >= EXP_MAX)
      float_o = {sign_i, INF_MAG};
    else if (exp_adj <= 0)
      float_o = {sign_i, 31'b0};
    else
      float_o = {sign_i, exp_adj[7:0], frac};
  end

endmodule

// File: rtl/ieee754_norm_pack.sv
// Multi-cycle normalise (one bit per clock), round and pack stage.
// IEEE754_ROUND_NEAREST_EN selects round-to-nearest-even; otherwise truncation.
module ieee754_norm_pack
  import ieee754_pkg::*;
#(
  parameter int unsigned EXP_BIAS  = 127,
  parameter int unsigned MAX_SHIFT = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sign,
  input  logic [FRAC_W-1:0] fraction,
  input  logic [31:0]       exponent,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       float,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(MAX_SHIFT + 1);

  state_e             state_q;
  logic [FRAC_W-1:0]  mant_q;
  logic signed [31:0] exp_q;
  logic               sign_q;
  logic               zero_q;
  logic [CNT_W-1:0]   count_q;
  logic [31:0]        float_q;
  logic               out_valid_q;
  logic [31:0]        float_d;
  logic               g_w, r_w, s_w;

`ifdef IEEE754_ROUND_NEAREST_EN
  logic g_q, r_q, s_q;
  assign g_w = g_q;
  assign r_w = r_q;
  assign s_w = s_q;
`else
  assign g_w = 1'b0;
  assign r_w = 1'b0;
  assign s_w = 1'b0;
`endif

  ieee754_round_pack u_round_pack (
    .sign_i  (sign_q),
    .mant_i  (mant_q[MANT_W:0]),
    .exp_i   (exp_q),
    .g_i     (g_w),
    .r_i     (r_w),
    .s_i     (s_w),
    .zero_i  (zero_q),
    .float_o (float_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mant_q      <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      zero_q      <= 1'b0;
      count_q     <= '0;
      float_q     <= '0;
      out_valid_q <= 1'b0;
`ifdef IEEE754_ROUND_NEAREST_EN
      g_q         <= 1'b0;
      r_q         <= 1'b0;
      s_q         <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mant_q  <= fraction;
            // Re-bias the incoming exponent onto the IEEE single bias.
            exp_q   <= exponent - 32'(EXP_BIAS) + 32'(ieee754_pkg::EXP_BIAS);
            sign_q  <= sign;
            count_q <= '0;
            zero_q  <= (fraction == '0);
            state_q <= (fraction == '0) ? ROUND : NORM;
`ifdef IEEE754_ROUND_NEAREST_EN
            g_q     <= 1'b0;
            r_q     <= 1'b0;
            s_q     <= 1'b0;
`endif
          end
        end
        NORM: begin
          if (count_q == CNT_W'(MAX_SHIFT)) begin
            zero_q  <= 1'b1;
            state_q <= ROUND;
          end else if (|mant_q[FRAC_W-1:MANT_W+1]) begin
            mant_q  <= mant_q >> 1;
            exp_q   <= exp_q + 32'sd1;
            count_q <= count_q + 1'b1;
`ifdef IEEE754_ROUND_NEAREST_EN
            g_q     <= mant_q[0];
            r_q     <= g_q;
            s_q     <= s_q | r_q;
`endif
          end else if (!mant_q[MANT_W]) begin
            mant_q  <= mant_q << 1;
            exp_q   <= exp_q - 32'sd1;
            count_q <= count_q + 1'b1;
          end else begin
            state_q <= ROUND;
          end
        end
        ROUND: begin
          float_q     <= float_d;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign float     = float_q;

endmodule
